// File: rtl/lock_key_loader_pkg.sv
// Shared definitions for the serial key loader: frame geometry, FSM state
// encoding and the nibble-fold checksum used to validate a received key.
package lock_key_pkg;

  localparam int KEY_W   = 16;
  localparam int CHK_W   = 4;
  localparam int FRAME_W = KEY_W + CHK_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // XOR of all CHK_W-bit slices of the key.
  function automatic logic [CHK_W-1:0] chk_fold(input logic [KEY_W-1:0] key);
    logic [CHK_W-1:0] acc;
    acc = {CHK_W{1'b0}};
    for (int i = 0; i < KEY_W / CHK_W; i++) begin
      acc = acc ^ key[i*CHK_W +: CHK_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/lock_key_loader_sipo.sv
// Serial-in/parallel-out frame register with bit counter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - zero the counter and the shift register
//   shift_en    - accept sdi this cycle (shift right, sdi enters the MSB)
//   sdi         - serial data bit
//   full        - the counter points at the last bit of the frame
//   data        - the frame; after FRAME_W shifts the first bit sits at data[0]
module lock_key_sipo
  import lock_key_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               sdi,
  output logic               full,
  output logic [FRAME_W-1:0] data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [FRAME_W-1:0] data_r;
  logic [CNT_W-1:0]   count_r;

  assign full = (count_r == LAST_CNT);
  assign data = data_r;

  // Shift register and bit counter; the counter wraps to zero on the last
  // bit so it is already cleared when the frame is checked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= {FRAME_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      data_r  <= {FRAME_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      data_r  <= {sdi, data_r[FRAME_W-1:1]};
      count_r <= full ? {CNT_W{1'b0}} : (count_r + ONE_CNT);
    end else begin
      data_r  <= data_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// One-time serial key loader for the locked netlist's key inputs.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   key_valid    - serial bit valid
//   key_sdi      - serial bit (key LSB first, then checksum LSB first)
//   key_ready    - loader accepts a bit this cycle (registered, state only)
//   key_clear    - abort a partial frame
//   key_out      - registered key bus, bit i drives netlist key input i
//   key_applied  - level, high once a key has been committed
//   key_err      - one-cycle pulse on checksum mismatch
module lock_key_loader
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic             key_sdi,
  output logic             key_ready,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_applied,
  output logic             key_err
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               ready_r;
  logic               ready_nxt_s;
  logic [KEY_W-1:0]   key_out_r;
  logic               applied_r;
  logic               err_r;

  logic               loading_s;
  logic               accept_s;
  logic               clr_s;
  logic               shift_en_s;
  logic               commit_s;
  logic               mismatch_s;
  logic               full_s;
  logic               match_s;
  logic [FRAME_W-1:0] frame_s;

  // Clear beats a coinciding bit; nothing is accepted outside IDLE/SHIFT.
  assign loading_s = (state_r == IDLE) || (state_r == SHIFT);
  assign clr_s     = loading_s && key_clear;
  assign accept_s  = loading_s && key_valid && !key_clear;
  assign match_s   = (chk_fold(frame_s[KEY_W-1:0]) == frame_s[FRAME_W-1:KEY_W]);

  lock_key_sipo u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .sdi      (key_sdi),
    .full     (full_s),
    .data     (frame_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr_s) begin
          state_nxt_s = IDLE;
        end else if (accept_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (clr_s) begin
          state_nxt_s = IDLE;
        end else if (accept_s && full_s) begin
          state_nxt_s = CHECK;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      CHECK: begin
        if (match_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED:  state_nxt_s = LOCKED;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes and the next value of key_ready.
  always_comb begin
    shift_en_s  = 1'b0;
    commit_s    = 1'b0;
    mismatch_s  = 1'b0;
    ready_nxt_s = (state_nxt_s == IDLE) || (state_nxt_s == SHIFT);
    case (state_r)
      IDLE, SHIFT: begin
        shift_en_s = accept_s;
      end
      CHECK: begin
        if (match_s) begin
          commit_s = 1'b1;
        end else begin
          mismatch_s = 1'b1;
        end
      end
      LOCKED: begin
        shift_en_s = 1'b0;
      end
      default: begin
        shift_en_s = 1'b0;
      end
    endcase
  end

  // Output registers; key_out is written only on a commit, so it changes at
  // most once between resets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_r   <= 1'b1;
      key_out_r <= {KEY_W{1'b0}};
      applied_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      ready_r   <= ready_nxt_s;
      key_out_r <= commit_s ? frame_s[KEY_W-1:0] : key_out_r;
      applied_r <= applied_r || commit_s;
      err_r     <= mismatch_s;
    end
  end

  assign key_ready   = ready_r;
  assign key_out     = key_out_r;
  assign key_applied = applied_r;
  assign key_err     = err_r;

endmodule

// File: tb/tb_lock_key_loader.sv
// Self-checking bench for lock_key_loader: table-driven frames plus
// hand-written corner sequences, outcomes checked through a scoreboard.
module tb_lock_key_loader;
  import lock_key_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             key_valid;
  logic             key_sdi;
  logic             key_ready;
  logic             key_clear;
  logic [KEY_W-1:0] key_out;
  logic             key_applied;
  logic             key_err;

  always #5 clk = ~clk;

  lock_key_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_sdi     (key_sdi),
    .key_ready   (key_ready),
    .key_clear   (key_clear),
    .key_out     (key_out),
    .key_applied (key_applied),
    .key_err     (key_err)
  );

  typedef struct {
    logic [15:0] key_out;
    logic        applied;
    logic        err;
    int          edge_n;
  } exp_t;

  typedef struct {
    logic [15:0] key;
    logic [3:0]  chk;
    bit          gap;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        rst_edge = 1'b1;
  logic [15:0] committed;

  function automatic logic [3:0] ref_fold(input logic [15:0] k);
    return k[3:0] ^ k[7:4] ^ k[11:8] ^ k[15:12];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  // Outcome monitor: sampled on the falling edge, pops the scoreboard.
  logic        prev_applied = 1'b0;
  logic        prev_err     = 1'b0;
  logic [15:0] prev_key     = 16'h0000;
  always @(negedge clk) begin
    exp_t e;
    if (key_err === 1'b1 || (key_applied === 1'b1 && !prev_applied)) begin
      if (sb.size() == 0) begin
        check("unexpected_outcome", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("key_out", {16'h0, key_out}, {16'h0, e.key_out});
        check("key_applied", {31'h0, key_applied}, {31'h0, e.applied});
        check("key_err", {31'h0, key_err}, {31'h0, e.err});
        check("latency", cyc, e.edge_n + 1);
        check("ready_after", {31'h0, key_ready}, {31'h0, !e.applied});
      end
    end
    if (key_err === 1'b1 && prev_err) check("err_width", 32'd2, 32'd1);
    if (!rst_edge && prev_applied && key_out !== prev_key)
      check("key_frozen", {16'h0, key_out}, {16'h0, prev_key});
    prev_applied = (key_applied === 1'b1);
    prev_err     = (key_err === 1'b1);
    prev_key     = key_out;
  end

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_sdi   = 1'b0;
    key_clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    committed = 16'h0000;
    check("rst_key_out", {16'h0, key_out}, 32'h0);
    check("rst_applied", {31'h0, key_applied}, 32'h0);
    check("rst_err", {31'h0, key_err}, 32'h0);
    check("rst_ready", {31'h0, key_ready}, 32'h1);
  endtask

  // Sends a full frame; pushes the expected outcome after the last accept.
  task automatic send_frame(input logic [15:0] key, input logic [3:0] chk, input bit gap);
    logic [19:0] frame;
    bit          pass;
    exp_t        e;
    frame = {chk, key};
    pass  = (ref_fold(key) == chk);
    for (int i = 0; i < 20; i++) begin
      key_valid = 1'b1;
      key_sdi   = frame[i];
      @(posedge clk);
      #1;
      if (i == 19) begin
        if (pass) committed = key;
        e.key_out = committed;
        e.applied = pass;
        e.err     = !pass;
        e.edge_n  = cyc;
        sb.push_back(e);
      end
      if (gap) begin
        key_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic wait_outcome();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("outcome_pending", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] frame;
    vecs[0] = '{16'h1234, 4'h4, 1'b0};
    vecs[1] = '{16'hA5C3, 4'h1, 1'b0};
    vecs[2] = '{16'hA5C3, 4'h0, 1'b0};
    vecs[3] = '{16'hBEEF, 4'h4, 1'b0};
    vecs[4] = '{16'h1234, 4'h4, 1'b1};
    vecs[5] = '{16'h0000, 4'h0, 1'b0};
    vecs[6] = '{16'hFFFF, 4'h1, 1'b1};
    vecs[7] = '{16'h00FF, 4'h0, 1'b0};

    // Table: each frame from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset(2);
      send_frame(vecs[v].key, vecs[v].chk, vecs[v].gap);
      wait_outcome();
    end

    // Mismatch, then a good frame without reset.
    do_reset(2);
    send_frame(16'hA5C3, 4'h1, 1'b0);
    wait_outcome();
    check("err_key_out_zero", {16'h0, key_out}, 32'h0);
    send_frame(16'hA5C3, 4'h0, 1'b0);
    wait_outcome();

    // Clear coinciding with the 10th bit drops it; a fresh frame commits.
    do_reset(2);
    frame = {ref_fold(16'h00FF), 16'h00FF};
    for (int i = 0; i < 9; i++) begin
      key_valid = 1'b1;
      key_sdi   = frame[i];
      @(posedge clk);
      #1;
    end
    key_valid = 1'b1;
    key_sdi   = frame[9];
    key_clear = 1'b1;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    key_valid = 1'b0;
    check("clear_ready", {31'h0, key_ready}, 32'h1);
    @(posedge clk);
    #1;
    send_frame(16'h00FF, ref_fold(16'h00FF), 1'b0);
    wait_outcome();
    check("clear_key_out", {16'h0, key_out}, 32'h00FF);

    // LOCKED ignores a new frame and clear pulses.
    do_reset(2);
    send_frame(16'h1234, 4'h4, 1'b0);
    wait_outcome();
    frame = {4'h0, 16'hFFFF};
    for (int i = 0; i < 24; i++) begin
      key_valid = 1'b1;
      key_sdi   = frame[i % 20];
      key_clear = (i % 3 == 0);
      @(posedge clk);
      #1;
      check("locked_ready", {31'h0, key_ready}, 32'h0);
      check("locked_key_out", {16'h0, key_out}, 32'h1234);
    end
    key_valid = 1'b0;
    key_clear = 1'b0;

    // One-cycle reset in LOCKED loses the key; a reload commits.
    do_reset(1);
    send_frame(16'hBEEF, 4'h4, 1'b0);
    wait_outcome();
    check("reload_key_out", {16'h0, key_out}, 32'hBEEF);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
